lcd_spi_engine: RTL and testbench

Parametrised, buffered SPI transmit engine for the ILI9341 display path. It replaces the fixed 8-bit command shifter with a word FIFO. Each FIFO entry carries its own data/command flag and end-of-burst marker. The engine keeps chip-select low across a whole burst and drives the `dc` line per word. It sits between the display controllers (init sequencer, pixel writer) and the panel pins.

---
 rtl/lcd_spi_engine.sv | 190 +++++++++++++++++++
 tb/tb_lcd_spi_engine.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_spi_engine.sv
// lcd_spi_engine: buffered SPI transmit engine for the ILI9341 panel path.
// Word FIFO with per-entry dc/last flags; cs held low across a burst.
// Ports: clk, rst (async active-low); s_valid/s_ready/s_data/s_dc/s_last
//   write side; sclk/mosi/dc/cs panel pins (mode 0); miso panel read data;
//   busy, fifo_level status; rx_data/rx_valid readback.
// Optional feature macro: SPI_READBACK_EN (adds rx_data/rx_valid).
module lcd_spi_engine #(
  parameter int DATA_W     = 8,
  parameter int CLK_DIV    = 2,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [DATA_W-1:0]           s_data,
  input  logic                        s_dc,
  input  logic                        s_last,
  input  logic                        miso,
  output logic                        sclk,
  output logic                        mosi,
  output logic                        dc,
  output logic                        cs,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
`ifdef SPI_READBACK_EN
  ,
  output logic [DATA_W-1:0]           rx_data,
  output logic                        rx_valid
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = DATA_W + 2;
  localparam int CW = $clog2(CLK_DIV) + 1;
  localparam int BW = $clog2(DATA_W);
  localparam logic [LW-1:0] FULL = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE, SETUP, SHIFT, NEXT, HOLD
  } state_t;

  state_t             state;
  logic [EW-1:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]      wptr, rptr;
  logic [LW-1:0]      count;
  logic [EW-1:0]      head;
  logic               push, pop;
  logic [CW-1:0]      cnt;
  logic [BW-1:0]      bitcnt;
  logic [DATA_W-1:0]  shreg;
  logic               last_r;
  logic               cnt_done, bit_done;

  assign s_ready    = (count != FULL);
  assign push       = s_valid && s_ready;
  assign head       = mem[rptr];
  assign fifo_level = count;
  assign busy       = !cs || (count != '0);
  assign cnt_done   = (cnt == CW'(CLK_DIV - 1));
  assign bit_done   = (bitcnt == BW'(DATA_W - 1));

  // A new word is taken only from IDLE, or from NEXT while the burst
  // is still open; a finished burst must go through HOLD first.
  assign pop = (count != '0) &&
               ((state == IDLE) || (state == NEXT && !last_r));

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {s_dc, s_last, s_data};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      bitcnt <= '0;
      shreg  <= '0;
      last_r <= 1'b0;
      sclk   <= 1'b0;
      mosi   <= 1'b0;
      dc     <= 1'b0;
      cs     <= 1'b1;
    end else begin
      if (pop) begin
        shreg  <= head[DATA_W-1:0];
        last_r <= head[DATA_W];
        dc     <= head[DATA_W+1];
        mosi   <= head[DATA_W-1];
        cs     <= 1'b0;
        cnt    <= '0;
      end
      case (state)
        IDLE: begin
          if (pop) state <= SETUP;
        end
        SETUP: begin
          if (cnt_done) begin
            cnt    <= '0;
            bitcnt <= '0;
            sclk   <= 1'b1;
            state  <= SHIFT;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        SHIFT: begin
          if (!cnt_done) begin
            cnt <= cnt + CW'(1);
          end else begin
            cnt  <= '0;
            sclk <= !sclk;
            if (sclk) begin
              if (bit_done) begin
                state <= NEXT;
              end else begin
                bitcnt <= bitcnt + BW'(1);
                shreg  <= shreg << 1;
                mosi   <= shreg[DATA_W-2];
              end
            end
          end
        end
        NEXT: begin
          if (last_r) begin
            cnt   <= '0;
            state <= HOLD;
          end else if (pop) begin
            state <= SETUP;
          end
        end
        HOLD: begin
          if (cnt_done) begin
            cnt   <= '0;
            cs    <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPI_READBACK_EN
  logic              rise, final_fall;
  logic [DATA_W-1:0] rx_sh;

  // The first rise of each word is issued from SETUP, later ones from SHIFT.
  assign rise = cnt_done &&
                ((state == SETUP) || (state == SHIFT && !sclk));
  assign final_fall = (state == SHIFT) && sclk && cnt_done && bit_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_sh    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (rise) rx_sh <= {rx_sh[DATA_W-2:0], miso};
      if (final_fall) begin
        rx_data  <= rx_sh;
        rx_valid <= 1'b1;
      end
    end
  end
`else
  logic unused_miso;
  assign unused_miso = miso;
`endif

endmodule

// File: tb/tb_lcd_spi_engine.sv
// tb_lcd_spi_engine: randomized self-checking bench for lcd_spi_engine.
// A pin-level SPI decoder rebuilds words and bursts from sclk/mosi/dc/cs.
module tb_lcd_spi_engine;

  localparam int DW = 8;
  localparam int CD = 2;
  localparam int FD = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s_valid = 1'b0;
  logic       s_dc = 1'b0;
  logic       s_last = 1'b0;
  logic       miso = 1'b0;
  logic [7:0] s_data = '0;
  logic       s_ready, sclk, mosi, dc, cs, busy;
  logic [4:0] fifo_level;
`ifdef SPI_READBACK_EN
  logic [7:0] rx_data;
  logic       rx_valid;
`endif

  lcd_spi_engine #(.DATA_W(DW), .CLK_DIV(CD), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_dc(s_dc), .s_last(s_last), .miso(miso),
    .sclk(sclk), .mosi(mosi), .dc(dc), .cs(cs),
    .busy(busy), .fifo_level(fifo_level)
`ifdef SPI_READBACK_EN
    , .rx_data(rx_data), .rx_valid(rx_valid)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Expected and observed words: {dc, last, data}
  logic [9:0] expq[$];
  logic [9:0] obs[$];
  time        rise_t[$];
  time        cs_fall_t, cs_rise_t, last_fall_t, tp;
  int         nbits = 0;
  logic [7:0] sh = '0;
  int         viol = 0;
  int         cs_falls = 0;

  always @(posedge sclk) begin
    if (cs !== 1'b0) viol++;
    sh = {sh[6:0], mosi};
    nbits++;
    rise_t.push_back($time);
    if (nbits == 8) begin
      obs.push_back({dc, 1'b0, sh});
      nbits = 0;
    end
  end

  always @(negedge sclk) last_fall_t = $time;

  always @(negedge cs) begin
    cs_fall_t = $time;
    cs_falls++;
    nbits = 0;
  end

  always @(posedge cs) begin
    logic [9:0] t;
    cs_rise_t = $time;
    if (obs.size() > 0) begin
      t = obs.pop_back();
      t[8] = 1'b1;
      obs.push_back(t);
    end
  end

  always @(dc) if (sclk === 1'b1) viol++;

  // Full-FIFO watcher
  logic mon_full = 1'b0;
  logic saw_full = 1'b0;
  int   full_bad = 0;
  always @(negedge clk) begin
    if (mon_full) begin
      if (s_ready !== (fifo_level != 5'd16) || fifo_level > 5'd16)
        full_bad++;
      if (s_ready === 1'b0) saw_full = 1'b1;
    end
  end

`ifdef SPI_READBACK_EN
  logic [7:0] rb_pat = 8'h00;
  int         rb_idx = -1;
  int         rx_cnt = 0;
  logic [7:0] rx_seen = '0;
  always @(negedge cs) begin
    miso = rb_pat[7];
    rb_idx = 6;
  end
  always @(posedge sclk) begin
    #1;
    if (rb_idx >= 0) begin
      miso = rb_pat[rb_idx];
      rb_idx--;
    end
  end
  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      rx_cnt++;
      rx_seen = rx_data;
    end
  end
`endif

  task automatic mon_clear();
    obs.delete();
    expq.delete();
    rise_t.delete();
    nbits = 0;
    viol = 0;
    cs_falls = 0;
  endtask

  task automatic push(input logic d, input logic l, input logic [7:0] v);
    int n;
    @(negedge clk);
    s_valid = 1'b1;
    s_dc    = d;
    s_last  = l;
    s_data  = v;
    n = 0;
    while (s_ready !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      checks++; errors++;
      $display("FAIL push_timeout: s_ready stuck at %b, expected 1", s_ready);
    end
    @(posedge clk);
    tp = $time;
    expq.push_back({d, l, v});
  endtask

  task automatic stop_push();
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      checks++; errors++;
      $display("FAIL idle_timeout: busy=%b after %0d cycles, expected 0", busy, n);
    end
  endtask

  task automatic cmp_words(input string name);
    checks++;
    if (obs.size() != expq.size()) begin
      errors++;
      $display("FAIL %s_count: got %0d words, expected %0d", name, obs.size(), expq.size());
    end else begin
      foreach (expq[i]) begin
        checks++;
        if (obs[i] !== expq[i]) begin
          errors++;
          $display("FAIL %s_word%0d: got %h expected %h (dc,last,data)", name, i, obs[i], expq[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL rst_sclk: got %b expected 0", sclk); end
    checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL rst_mosi: got %b expected 0", mosi); end
    checks++; if (dc !== 1'b0) begin errors++; $display("FAIL rst_dc: got %b expected 0", dc); end
    checks++; if (cs !== 1'b1) begin errors++; $display("FAIL rst_cs: got %b expected 1", cs); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b expected 1", s_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL rst_level: got %0d expected 0", fifo_level); end
`ifdef SPI_READBACK_EN
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rst_rx_data: got %h expected 00", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rst_rx_valid: got %b expected 0", rx_valid); end
`endif
    rst = 1'b1;
    repeat (2) @(negedge clk);
    mon_clear();
  endtask

  task automatic test_single();
    bit sp_ok;
    mon_clear();
    push(1'b0, 1'b1, 8'h2A);
    stop_push();
    checks++;
    if (fifo_level !== 5'd1) begin
      errors++; $display("FAIL single_level: got %0d expected 1", fifo_level);
    end
    wait_idle();
    checks++;
    if (cs_fall_t - tp != 10) begin
      errors++; $display("FAIL single_cs_latency: got %0t expected 10", cs_fall_t - tp);
    end
    checks++;
    if (rise_t.size() != 8) begin
      errors++; $display("FAIL single_rises: got %0d expected 8", rise_t.size());
    end else begin
      sp_ok = 1'b1;
      for (int i = 1; i < 8; i++) if (rise_t[i] - rise_t[i-1] != 40) sp_ok = 1'b0;
      checks++;
      if (!sp_ok) begin errors++; $display("FAIL single_period: got irregular, expected 40"); end
      checks++;
      if (rise_t[0] - cs_fall_t != 20) begin
        errors++; $display("FAIL single_first_rise: got %0t expected 20", rise_t[0] - cs_fall_t);
      end
    end
    checks++;
    if (cs_rise_t - last_fall_t != 30) begin
      errors++; $display("FAIL single_cs_hold: got %0t expected 30", cs_rise_t - last_fall_t);
    end
    checks++;
    if (viol != 0) begin errors++; $display("FAIL single_viol: got %0d expected 0", viol); end
    cmp_words("single");
  endtask

  task automatic test_burst();
    mon_clear();
    push(1'b0, 1'b0, 8'h2C);
    push(1'b1, 1'b0, 8'hF8);
    push(1'b1, 1'b1, 8'hE0);
    stop_push();
    wait_idle();
    checks++;
    if (cs_falls != 1) begin errors++; $display("FAIL burst_cs_falls: got %0d expected 1", cs_falls); end
    checks++;
    if (rise_t.size() != 24) begin
      errors++; $display("FAIL burst_rises: got %0d expected 24", rise_t.size());
    end else begin
      checks++;
      if (rise_t[8] - rise_t[7] != 50) begin
        errors++; $display("FAIL burst_gap1: got %0t expected 50", rise_t[8] - rise_t[7]);
      end
      checks++;
      if (rise_t[16] - rise_t[15] != 50) begin
        errors++; $display("FAIL burst_gap2: got %0t expected 50", rise_t[16] - rise_t[15]);
      end
    end
    checks++;
    if (viol != 0) begin errors++; $display("FAIL burst_viol: got %0d expected 0", viol); end
    cmp_words("burst");
  endtask

  task automatic test_stall();
    int bad;
    mon_clear();
    push(1'b1, 1'b0, 8'($urandom));
    stop_push();
    repeat (40) @(negedge clk);
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (cs !== 1'b0 || sclk !== 1'b0 || busy !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL stall_hold: got %0d bad cycles expected 0", bad); end
    push(1'b1, 1'b1, 8'($urandom));
    stop_push();
    wait_idle();
    checks++;
    if (cs_falls != 1) begin errors++; $display("FAIL stall_cs_falls: got %0d expected 1", cs_falls); end
    cmp_words("stall");
  endtask

  task automatic test_full();
    mon_clear();
    full_bad = 0;
    saw_full = 1'b0;
    mon_full = 1'b1;
    for (int i = 0; i < 20; i++)
      push(1'($urandom), (i == 19) ? 1'b1 : 1'($urandom_range(0, 3) == 0), 8'($urandom));
    stop_push();
    wait_idle();
    mon_full = 1'b0;
    checks++;
    if (full_bad != 0) begin errors++; $display("FAIL full_ready_rule: got %0d bad cycles expected 0", full_bad); end
    checks++;
    if (saw_full !== 1'b1) begin errors++; $display("FAIL full_seen: got %b expected 1", saw_full); end
    cmp_words("full");
  endtask

  task automatic test_random();
    int n, lasts;
    logic l;
    for (int r = 0; r < 3; r++) begin
      mon_clear();
      n = $urandom_range(5, 12);
      lasts = 0;
      for (int i = 0; i < n; i++) begin
        l = (i == n - 1) ? 1'b1 : 1'($urandom_range(0, 2) == 0);
        if (l) lasts++;
        push(1'($urandom), l, 8'($urandom));
        if ($urandom_range(0, 1) == 1) begin
          stop_push();
          repeat ($urandom_range(0, 40)) @(negedge clk);
        end
      end
      stop_push();
      wait_idle();
      checks++;
      if (cs_falls != lasts) begin
        errors++; $display("FAIL rand%0d_bursts: got %0d expected %0d", r, cs_falls, lasts);
      end
      checks++;
      if (viol != 0) begin errors++; $display("FAIL rand%0d_viol: got %0d expected 0", r, viol); end
      cmp_words("rand");
    end
  endtask

  task automatic test_reset_mid();
    int n;
    mon_clear();
    push(1'b0, 1'b0, 8'($urandom));
    push(1'b1, 1'b0, 8'($urandom));
    push(1'b1, 1'b1, 8'($urandom));
    stop_push();
    n = 0;
    while (rise_t.size() < 3 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      checks++; errors++;
      $display("FAIL mid_wait: got %0d rises expected 3", rise_t.size());
    end
    rst = 1'b0;
    #1;
    checks++; if (cs !== 1'b1) begin errors++; $display("FAIL mid_cs: got %b expected 1", cs); end
    checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL mid_sclk: got %b expected 0", sclk); end
    checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL mid_level: got %0d expected 0", fifo_level); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", busy); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    mon_clear();
    repeat (60) @(negedge clk);
    checks++;
    if (rise_t.size() != 0 || cs_falls != 0) begin
      errors++; $display("FAIL mid_quiet: got %0d rises %0d cs falls expected 0", rise_t.size(), cs_falls);
    end
    push(1'b0, 1'b1, 8'($urandom));
    stop_push();
    wait_idle();
    cmp_words("mid_after");
  endtask

`ifdef SPI_READBACK_EN
  task automatic test_readback();
    logic [7:0] pats [2];
    pats[0] = 8'hA5;
    pats[1] = 8'($urandom);
    for (int k = 0; k < 2; k++) begin
      mon_clear();
      rb_pat = pats[k];
      rx_cnt = 0;
      push(1'b0, 1'b1, 8'($urandom));
      stop_push();
      wait_idle();
      checks++;
      if (rx_cnt != 1) begin errors++; $display("FAIL rb%0d_strobes: got %0d expected 1", k, rx_cnt); end
      checks++;
      if (rx_seen !== pats[k]) begin errors++; $display("FAIL rb%0d_data: got %h expected %h", k, rx_seen, pats[k]); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_stall();
    test_full();
    test_random();
    test_reset_mid();
`ifdef SPI_READBACK_EN
    test_readback();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
